// File: rtl/data_memory_block_if.sv
// Block-level memory bus between the data cache (master) and the data memory (slave).
interface data_memory_block_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  busywait;

  modport master (output read, write, address, writedata, input readdata, busywait);
  modport slave  (input read, write, address, writedata, output readdata, busywait);
endinterface

// File: rtl/data_memory_block.sv
// Block-granular data memory with a fixed multi-cycle latency; busywait drops
// for exactly one cycle (ACK) when an access completes.
module data_memory_block #(
  parameter int LATENCY    = 5,
  parameter int ADDR_WIDTH = 6
) (
  input logic                 clock,
  input logic                 reset,
  data_memory_block_if.slave  bus
);
  localparam int NUM_BYTES = 4 * (2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                state, state_n;
  logic [3:0]            count;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_data;
  logic [31:0]           readdata_q;
  logic [31:0]           block_rd;
  logic                  busy;
  logic                  request;
  logic                  access_now;

  // NOTE: storage has no reset term so it maps onto RAM; only the initial
  // value is zeroed, reset never clears contents.
  logic [7:0] mem [0:NUM_BYTES-1] = '{default: 8'h00};

  assign request    = bus.read | bus.write;
  assign access_now = (state == ACCESS) && (count == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so no latch is inferred; clocked blocks use <= only.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        busy = request;
        if (request) state_n = ACCESS;
      end
      ACCESS: begin
        busy = 1'b1;
        if (count == 4'd0) state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (reset) busy = 1'b0;
  end

  always_comb begin
    block_rd = '0;
    for (int k = 0; k < 4; k++)
      block_rd[8*k +: 8] = mem[{lat_addr, 2'(k)}];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= 4'd0;
      op_write   <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (request) begin
          op_write <= bus.write;   // write wins when both are high
          lat_addr <= bus.address;
          lat_data <= bus.writedata;
          count    <= 4'(LATENCY - 1);
        end
        ACCESS: begin
          if (count != 4'd0)  count      <= count - 4'd1;
          else if (!op_write) readdata_q <= block_rd;
        end
        default: ;
      endcase
    end
  end

  // An access aborted by reset never reaches this write: state is forced to IDLE.
  always_ff @(posedge clock) begin
    if (!reset && access_now && op_write)
      for (int k = 0; k < 4; k++)
        mem[{lat_addr, 2'(k)}] <= lat_data[8*k +: 8];
  end

  assign bus.busywait = busy;
  assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_data_memory_block.sv
// Directed bench for data_memory_block: a vector table of complete
// transactions plus hand-written multi-cycle sequences.
module tb_data_memory_block;
  localparam int LAT = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  data_memory_block_if #(.ADDR_WIDTH(6)) bus();

  data_memory_block #(.LATENCY(LAT), .ADDR_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // First posedge is the accepting edge; counts edges until busywait is seen low.
  task automatic wait_done(output int lat);
    lat = 0;
    @(posedge clock);
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus.busywait && lat < 50);
  endtask

  task automatic drop_req();
    @(negedge clock);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [5:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    int lat;
    @(negedge clock);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
    #1 check({name, " busy_now"}, 32'(bus.busywait), 32'd1);
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(LAT));
    drop_req();
    check({name, " readdata"}, bus.readdata, exp_rd);
    @(posedge clock);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    vecs[0] = '{"rd_00_after_reset", 1'b1, 1'b0, 6'h00, 32'h0,        32'h0};
    vecs[1] = '{"wr_2A",             1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{"rd_2A",             1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{"rdwr_3F",           1'b1, 1'b1, 6'h3F, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[4] = '{"rd_3F",             1'b1, 1'b0, 6'h3F, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{"wr_01",             1'b0, 1'b1, 6'h01, 32'h01020304, 32'hCAFEF00D};
    vecs[6] = '{"rd_01",             1'b1, 1'b0, 6'h01, 32'h0,        32'h01020304};

    bus.read = 1'b1; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    reset = 1'b1;
    #1 check("reset busywait", 32'(bus.busywait), 32'd0);
    check("reset readdata", bus.readdata, 32'h0);
    bus.read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    foreach (vecs[i])
      do_req(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    check("mem[168]", 32'(dut.mem[168]), 32'hEF);
    check("mem[171]", 32'(dut.mem[171]), 32'hDE);

    // Back-to-back: read held across ACK.
    @(negedge clock);
    bus.read = 1'b1; bus.address = 6'h2A;
    wait_done(lat);
    check("b2b first latency", 32'(lat), 32'(LAT));
    @(posedge clock);
    #1 check("b2b busy after one-cycle ack", 32'(bus.busywait), 32'd1);
    wait_done(lat);
    check("b2b second latency", 32'(lat), 32'(LAT));
    check("b2b readdata", bus.readdata, 32'hDEADBEEF);
    drop_req();
    @(posedge clock);

    // Inputs changed two cycles into ACCESS must be ignored.
    @(negedge clock);
    bus.write = 1'b1; bus.address = 6'h05; bus.writedata = 32'h11223344;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    bus.address = 6'h06; bus.writedata = 32'hFFFFFFFF;
    lat = 1;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (bus.busywait && lat < 50);
    check("midchg latency", 32'(lat), 32'(LAT));
    drop_req();
    @(posedge clock);
    do_req("midchg rd_05", 1'b1, 1'b0, 6'h05, 32'h0, 32'h11223344);
    do_req("midchg rd_06", 1'b1, 1'b0, 6'h06, 32'h0, 32'h0);

    // Reset in ACCESS cycle 3 aborts the write; held read accepted after release.
    do_req("preload wr_10", 1'b0, 1'b1, 6'h10, 32'hA5A5A5A5, 32'h0);
    do_req("preload rd_10", 1'b1, 1'b0, 6'h10, 32'h0, 32'hA5A5A5A5);
    @(negedge clock);
    bus.write = 1'b1; bus.address = 6'h10; bus.writedata = 32'h12345678;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; bus.write = 1'b0; bus.read = 1'b1;
    #1 check("midrst busywait", 32'(bus.busywait), 32'd0);
    check("midrst readdata", bus.readdata, 32'h0);
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    #1 check("release busy_now", 32'(bus.busywait), 32'd1);
    wait_done(lat);
    check("release latency", 32'(lat), 32'(LAT));
    drop_req();
    check("midrst rd_10", bus.readdata, 32'hA5A5A5A5);
    @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
